// File: rtl/mem_debug_dumper_pkg.sv
// Shared types and constants for the memory debug dumper.
// Holds the FSM encodings and the byte/word sizing constants.
package mem_dump_pkg;

   localparam int BYTE_W         = 8;
   localparam int DEF_DATA_W     = 32;
   localparam int BYTES_PER_WORD = DEF_DATA_W / BYTE_W;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      CAPT,
      SEND,
      WAIT_TX,
      NEXT,
      FIN,
      CSUM
   } state_t;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_SEND,
      SER_WAIT
   } ser_state_t;

endpackage

// File: rtl/mem_debug_dumper_if.sv
// Memory debug read port plus UART byte handshake.
// master = dumper side, slave = memory/uart side.
interface mem_debug_dumper_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              Debug_on;
   logic [ADDR_W-1:0] Debug_read_mem;
   logic [DATA_W-1:0] mem_data;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_done;

   modport master (
      output Debug_on,
      output Debug_read_mem,
      output tx_data,
      output tx_start,
      input  mem_data,
      input  tx_done
   );

   modport slave (
      input  Debug_on,
      input  Debug_read_mem,
      input  tx_data,
      input  tx_start,
      output mem_data,
      output tx_done
   );
endinterface

// File: rtl/mem_debug_dumper_word_byte_serializer.sv
// Splits a captured word into bytes, MSB first, over tx_start/tx_done.
// Ports: word_valid/word in, word_sent out (comb), tx_* to uart_tx.
// MEM_DUMP_CHECKSUM_EN adds acc_clr/csum_valid and an XOR accumulator.
module word_byte_serializer
   import mem_dump_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              word_valid,
   input  logic [DATA_W-1:0] word,
`ifdef MEM_DUMP_CHECKSUM_EN
   input  logic              acc_clr,
   input  logic              csum_valid,
`endif
   input  logic              tx_done,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_start,
   output logic              word_sent
);

   localparam int BPW = DATA_W / BYTE_W;
   localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

   ser_state_t        st;
   logic [DATA_W-1:0] word_q;
   logic [DATA_W-1:0] shifted;
   logic [IW-1:0]     byte_idx;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [BYTE_W-1:0] acc;
`endif

   // Next byte is always the top byte of the left-shifted word.
   assign shifted   = word_q << BYTE_W;
   assign word_sent = (st == SER_WAIT) && tx_done
                      && (byte_idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st       <= SER_IDLE;
         word_q   <= '0;
         byte_idx <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
         acc      <= '0;
`endif
      end else begin
         tx_start <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
         if (acc_clr) acc <= '0;
`endif
         unique case (st)
            SER_IDLE: begin
               if (word_valid) begin
                  word_q   <= word;
                  byte_idx <= '0;
                  tx_data  <= word[DATA_W-1 -: BYTE_W];
                  tx_start <= 1'b1;
                  st       <= SER_SEND;
`ifdef MEM_DUMP_CHECKSUM_EN
                  acc <= acc ^ word[DATA_W-1 -: BYTE_W];
               end else if (csum_valid) begin
                  // Parking the index on the last slot
                  // makes the checksum a one-byte "word".
                  byte_idx <= LAST_IDX;
                  tx_data  <= acc;
                  tx_start <= 1'b1;
                  st       <= SER_SEND;
`endif
               end
            end
            SER_SEND: st <= SER_WAIT;
            SER_WAIT: begin
               if (tx_done) begin
                  if (byte_idx == LAST_IDX) begin
                     st <= SER_IDLE;
                  end else begin
                     byte_idx <= byte_idx + IW'(1);
                     word_q   <= shifted;
                     tx_data  <= shifted[DATA_W-1 -: BYTE_W];
                     tx_start <= 1'b1;
                     st       <= SER_SEND;
`ifdef MEM_DUMP_CHECKSUM_EN
                     acc <= acc
                            ^ shifted[DATA_W-1 -: BYTE_W];
`endif
                  end
               end
            end
            default: st <= SER_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mem_debug_dumper.sv
// Walks memory words 0..DEPTH-1 over the debug port and streams them out.
// Ports: clk, rst (async low), start, bus (master), busy, dump_done.
// MEM_DUMP_CHECKSUM_EN appends an XOR checksum byte to each dump.
module mem_debug_dumper
   import mem_dump_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   mem_debug_dumper_if.master  bus,
   output logic                busy,
   output logic                dump_done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t        state;
   logic [AW-1:0] addr;
   logic          debug_on;
   logic          word_sent;
   logic [7:0]    tx_data;
   logic          tx_start;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic          csum_go;
`endif

   assign bus.Debug_on       = debug_on;
   assign bus.Debug_read_mem = ADDR_W'(addr);
   assign bus.tx_data        = tx_data;
   assign bus.tx_start       = tx_start;

   word_byte_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .word_valid (state == CAPT),
      .word       (bus.mem_data),
`ifdef MEM_DUMP_CHECKSUM_EN
      .acc_clr    ((state == IDLE) && start),
      .csum_valid (csum_go),
`endif
      .tx_done    (bus.tx_done),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .word_sent  (word_sent)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         addr      <= '0;
         debug_on  <= 1'b0;
         busy      <= 1'b0;
         dump_done <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
         csum_go   <= 1'b0;
`endif
      end else begin
         dump_done <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
         csum_go   <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= REQ;
                  addr     <= '0;
                  debug_on <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            // Memory samples addr on the negedge inside REQ.
            REQ:  state <= CAPT;
            CAPT: state <= SEND;
            SEND: state <= WAIT_TX;
            WAIT_TX: begin
               if (word_sent) state <= NEXT;
            end
            NEXT: begin
               if (addr == LAST) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                  state   <= CSUM;
                  csum_go <= 1'b1;
`else
                  state     <= FIN;
                  dump_done <= 1'b1;
`endif
               end else begin
                  addr  <= addr + AW'(1);
                  state <= REQ;
               end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            CSUM: begin
               if (word_sent) begin
                  state     <= FIN;
                  dump_done <= 1'b1;
               end
            end
`endif
            FIN: begin
               state    <= IDLE;
               debug_on <= 1'b0;
               busy     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_debug_dumper.md
Name: mem_debug_dumper

Overview:
- Debug-side initiator for the data memory's debug read port. It drives Debug_on and Debug_read_mem, and consumes outMemDebug.
- On a start pulse it walks addresses 0..DEPTH-1, captures each 32-bit word and serializes it as bytes into the UART transmitter over a start/done handshake.
- Sits between the debug unit (which halts the pipeline and issues start) and uart_tx.

Parameters:
- DEPTH, 32, number of memory words dumped (addresses 0..DEPTH-1).
- ADDR_W, 32, width of Debug_read_mem.
- DATA_W, 32, memory word width; must be a multiple of 8.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from the debug unit to begin a dump.
- Debug_on  out  1  high for the whole dump; selects the memory debug read path and blocks memory writes.
- Debug_read_mem  out  ADDR_W  word address being read.
- mem_data  in  DATA_W  connects to the memory's outMemDebug.
- tx_data  out  8  byte presented to uart_tx.
- tx_start  out  1  one-cycle pulse; tx_data is valid in the same cycle.
- tx_done  in  1  one-cycle pulse from uart_tx when the byte has been fully sent.
- busy  out  1  high in every state except IDLE.
- dump_done  out  1  one-cycle pulse after the last byte's tx_done.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - Debug_on=0, Debug_read_mem=0, tx_data=0, tx_start=0, busy=0, dump_done=0.
  - State=IDLE; address counter and byte index cleared.
- States: IDLE, REQ, CAPT, SEND, WAIT_TX, NEXT, FIN.
- IDLE: on start=1, go to REQ with addr=0 and Debug_on=1. start is ignored in every other state.
- REQ: Debug_read_mem=addr is stable. The memory samples it on the following negedge, so data is valid at the next posedge. Go to CAPT.
- CAPT: latch mem_data into the shift register, set byte_idx=0, go to SEND.
- SEND:
  - tx_data = word[DATA_W-1-8*byte_idx -: 8], i.e. MSB byte first.
  - tx_start=1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: hold tx_data. tx_done is sampled only in this state; a tx_done seen elsewhere is ignored. On tx_done:
  - if byte_idx < DATA_W/8-1: increment byte_idx, go to SEND;
  - otherwise go to NEXT.
- NEXT:
  - if addr == DEPTH-1, go to FIN;
  - otherwise addr+1, go to REQ.
  - addr never wraps; the counter is sized to hold DEPTH-1.
- FIN: dump_done=1 for one cycle, Debug_on=0, go to IDLE.
- Latency:
  - start to first tx_start: 3 cycles (IDLE→REQ→CAPT→SEND).
  - tx_done of a word's last byte to tx_start of the next word's first byte: 4 cycles.
- Debug_on stays high continuously from REQ through FIN, so no memory write can interleave with a dump.
- Reset mid-dump: outputs return to reset values immediately. A partially sent byte is abandoned. uart_tx is reset by the same rst.
- tx_start never asserts while in WAIT_TX; at most one byte is outstanding.

Optional Feature:
- Macro MEM_DUMP_CHECKSUM_EN.
- When defined:
  - an 8-bit XOR accumulator covers every byte sent; it is cleared on start;
  - after the last data byte, state CSUM sends the accumulator as one extra byte (tx_start pulse, wait tx_done), then goes to FIN;
  - total bytes per dump = DEPTH*DATA_W/8 + 1.
- When undefined: no CSUM state or accumulator logic; NEXT goes directly to FIN.

Decomposition:
- Shared package mem_dump_pkg holds:
  - state enum encoding (IDLE..FIN, CSUM);
  - BYTE_W=8;
  - BYTES_PER_WORD=DATA_W/8.
- One sub-module is natural: word_byte_serializer. It owns the shift register, byte_idx and the SEND/WAIT_TX handshake. It takes a word_valid pulse and returns word_sent. The top keeps the address FSM.

Test Plan:
- Memory model: words zero except word 20=0x00000AAA; uart_tx model returns tx_done 10 cycles after tx_start.
  - Pulse start → exactly 128 tx_start pulses.
  - Bytes 80..83 are 00,00,0A,AA; all other bytes are 00.
  - dump_done pulses once; Debug_on is high from cycle 1 to FIN.
- Word 0 = 0x12345678, start → first four tx_data are 12,34,56,78; first tx_start comes 3 cycles after start.
- start pulsed again during the dump at byte 40 → ignored; total tx_start count is still 128; Debug_read_mem never exceeds 31.
- rst=0 asserted while in WAIT_TX of word 5 → all outputs 0 in the same cycle (asynchronous). A later start restarts from address 0.
- Spurious tx_done injected in SEND/REQ → no byte is skipped; byte sequence unchanged.
- With MEM_DUMP_CHECKSUM_EN and word 0=0x12345678, others 0 → 129 bytes; last byte = 0x12^0x34^0x56^0x78 = 0x08.
